// File: rtl/sample_packer_if.sv
// rtl/sample_packer_if.sv - sample input / packed vector output bundle for sample_packer
interface sample_packer_if #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 8
);
  logic [DWIDTH-1:0]            i_dat;
  logic                         i_valid;
  logic                         i_last;
  logic                         o_ready;
  logic [NUM_INPUTS*DWIDTH-1:0] o_dat_vector;
  logic                         o_valid;
  logic                         i_ready;
  logic [$clog2(NUM_INPUTS):0]  o_lanes;

  modport slave (
    input  i_dat, i_valid, i_last, i_ready,
    output o_ready, o_dat_vector, o_valid, o_lanes
  );

  modport master (
    output i_dat, i_valid, i_last, i_ready,
    input  o_ready, o_dat_vector, o_valid, o_lanes
  );
endinterface

// File: rtl/sample_packer.sv
// rtl/sample_packer.sv - serial-to-parallel sample packer with fill buffer and output register
module sample_packer #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sample_packer_if.slave  bus
);
  localparam int VW = NUM_INPUTS * DWIDTH;
  localparam int LW = $clog2(NUM_INPUTS);
  localparam int CW = LW + 1;

  logic [VW-1:0] fill;
  logic [LW-1:0] cnt;
  logic          fill_full;
  logic [CW-1:0] fill_lanes;
  logic [VW-1:0] out_dat;
  logic [CW-1:0] out_lanes;
  logic          out_valid;

  logic          accept;
  logic          out_free;
  logic          complete;
  logic [CW-1:0] lanes_next;
  logic [VW-1:0] merged;

  assign accept     = bus.i_valid && !fill_full;
  assign out_free   = !out_valid || bus.i_ready;
  assign complete   = accept && ((cnt == LW'(NUM_INPUTS - 1)) || bus.i_last);
  assign lanes_next = CW'(cnt) + CW'(1);

  // Fill buffer with the incoming sample dropped into lane cnt.
  always_comb begin
    merged = fill;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (LW'(k) == cnt) merged[k*DWIDTH +: DWIDTH] = bus.i_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill       <= '0;
      cnt        <= '0;
      fill_full  <= 1'b0;
      fill_lanes <= '0;
      out_dat    <= '0;
      out_lanes  <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (out_valid && bus.i_ready) out_valid <= 1'b0;

      if (fill_full) begin
        // A held vector moves out as soon as the output register frees up.
        if (out_free) begin
          out_dat    <= fill;
          out_lanes  <= fill_lanes;
          out_valid  <= 1'b1;
          fill       <= '0;
          cnt        <= '0;
          fill_full  <= 1'b0;
        end
      end else if (accept) begin
        if (complete) begin
          if (out_free) begin
            out_dat   <= merged;
            out_lanes <= lanes_next;
            out_valid <= 1'b1;
            fill      <= '0;
          end else begin
            fill       <= merged;
            fill_lanes <= lanes_next;
            fill_full  <= 1'b1;
          end
          cnt <= '0;
        end else begin
          fill <= merged;
          cnt  <= cnt + LW'(1);
        end
      end
    end
  end

  assign bus.o_ready      = !fill_full;
  assign bus.o_valid      = out_valid;
  assign bus.o_dat_vector = out_dat;
  assign bus.o_lanes      = out_lanes;
endmodule
